// File: rtl/mrd_twdl_cmul_pipe.sv
// Twiddle complex-multiply stage for the mixed-radix FFT datapath: four-register pipeline with
// per-lane round/saturate, lane masking by radix, bypass, whole-pipe clock enable and sticky overflow.
module mrd_twdl_cmul_pipe #(
    parameter int wData     = 30,
    parameter int wTw       = 16,
    parameter int NLANE     = 5,
    parameter int wBankIdx  = 3,
    parameter int wBankAddr = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic                       in_val,
    input  logic [2:0]                 in_radix,
    input  logic                       in_bypass,
    input  logic [NLANE*wBankIdx-1:0]  in_bank_index,
    input  logic [NLANE*wBankAddr-1:0] in_bank_addr,
    input  logic [NLANE*wData-1:0]     din_real,
    input  logic [NLANE*wData-1:0]     din_imag,
    input  logic [NLANE*wTw-1:0]       tw_real,
    input  logic [NLANE*wTw-1:0]       tw_imag,
    input  logic                       clr_ovf,
    output logic                       out_val,
    output logic [NLANE*wBankIdx-1:0]  out_bank_index,
    output logic [NLANE*wBankAddr-1:0] out_bank_addr,
    output logic [NLANE*wData-1:0]     dout_real,
    output logic [NLANE*wData-1:0]     dout_imag,
    output logic                       ovf_sticky
);

    localparam int wProd = wData + wTw;
    localparam int wSum  = wProd + 1;
    localparam int SHIFT = wTw - 2;
    localparam int wRnd  = wSum - SHIFT;

    typedef logic signed [wData-1:0] data_t;
    typedef logic signed [wTw-1:0]   tw_t;
    typedef logic signed [wProd-1:0] prod_t;
    typedef logic signed [wSum-1:0]  sum_t;
    typedef logic signed [wRnd-1:0]  rnd_t;

    typedef struct packed {
        logic                       val;
        logic [2:0]                 radix;
        logic                       bypass;
        logic [NLANE*wBankIdx-1:0]  bidx;
        logic [NLANE*wBankAddr-1:0] baddr;
    } ctrl_t;

    localparam sum_t  RND_BIAS = sum_t'(1) <<< (wTw - 3);
    localparam data_t DATA_MAX = {1'b0, {(wData-1){1'b1}}};
    localparam data_t DATA_MIN = {1'b1, {(wData-1){1'b0}}};
    localparam rnd_t  RND_MAX  = rnd_t'(DATA_MAX);
    localparam rnd_t  RND_MIN  = rnd_t'(DATA_MIN);

    function automatic logic clamps(input rnd_t v);
        return (v > RND_MAX) || (v < RND_MIN);
    endfunction

    function automatic data_t saturate(input rnd_t v);
        if (v > RND_MAX)      return DATA_MAX;
        else if (v < RND_MIN) return DATA_MIN;
        else                  return data_t'(v);
    endfunction

    ctrl_t ctl_in, s1_ctl, s2_ctl, s3_ctl;

    assign ctl_in = '{val: in_val, radix: in_radix, bypass: in_bypass,
                      bidx: in_bank_index, baddr: in_bank_addr};

    // S1 operands; din also rides S2/S3 so bypass can emit it with unchanged latency.
    data_t s1_dr [NLANE];
    data_t s1_di [NLANE];
    tw_t   s1_tr [NLANE];
    tw_t   s1_ti [NLANE];
    data_t s2_dr [NLANE];
    data_t s2_di [NLANE];
    data_t s3_dr [NLANE];
    data_t s3_di [NLANE];
    prod_t s2_rr [NLANE];
    prod_t s2_ii [NLANE];
    prod_t s2_ri [NLANE];
    prod_t s2_ir [NLANE];
    sum_t  s3_re [NLANE];
    sum_t  s3_im [NLANE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctl <= '0;
            s2_ctl <= '0;
            s3_ctl <= '0;
        end else if (ce) begin
            // NOTE: non-blocking assignments let each stage read the previous stage's old value.
            s1_ctl <= ctl_in;
            s2_ctl <= s1_ctl;
            s3_ctl <= s2_ctl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these lane arrays are pipeline flops, not RAM, so every entry is reset to give clean zeros.
            for (int k = 0; k < NLANE; k++) begin
                s1_dr[k] <= '0;
                s1_di[k] <= '0;
                s1_tr[k] <= '0;
                s1_ti[k] <= '0;
                s2_dr[k] <= '0;
                s2_di[k] <= '0;
                s2_rr[k] <= '0;
                s2_ii[k] <= '0;
                s2_ri[k] <= '0;
                s2_ir[k] <= '0;
                s3_dr[k] <= '0;
                s3_di[k] <= '0;
                s3_re[k] <= '0;
                s3_im[k] <= '0;
            end
        end else if (ce) begin
            for (int k = 0; k < NLANE; k++) begin
                s1_dr[k] <= din_real[k*wData +: wData];
                s1_di[k] <= din_imag[k*wData +: wData];
                s1_tr[k] <= tw_real[k*wTw +: wTw];
                s1_ti[k] <= tw_imag[k*wTw +: wTw];

                s2_dr[k] <= s1_dr[k];
                s2_di[k] <= s1_di[k];
                s2_rr[k] <= prod_t'(s1_dr[k]) * prod_t'(s1_tr[k]);
                s2_ii[k] <= prod_t'(s1_di[k]) * prod_t'(s1_ti[k]);
                s2_ri[k] <= prod_t'(s1_dr[k]) * prod_t'(s1_ti[k]);
                s2_ir[k] <= prod_t'(s1_di[k]) * prod_t'(s1_tr[k]);

                s3_dr[k] <= s2_dr[k];
                s3_di[k] <= s2_di[k];
                s3_re[k] <= sum_t'(s2_rr[k]) - sum_t'(s2_ii[k]);
                s3_im[k] <= sum_t'(s2_ri[k]) + sum_t'(s2_ir[k]);
            end
        end
    end

    // S4 combinational: round half up, saturate, then apply bypass and lane mask.
    rnd_t                       re_rnd [NLANE];
    rnd_t                       im_rnd [NLANE];
    data_t                      nx_re  [NLANE];
    data_t                      nx_im  [NLANE];
    logic [NLANE-1:0]           lane_act;
    logic [NLANE-1:0]           lane_ovf;
    logic [NLANE*wBankIdx-1:0]  nx_bidx;
    logic [NLANE*wBankAddr-1:0] nx_baddr;
    logic                       ovf_set;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        lane_act = '0;
        lane_ovf = '0;
        nx_bidx  = '0;
        nx_baddr = '0;
        for (int k = 0; k < NLANE; k++) begin
            re_rnd[k]   = rnd_t'((s3_re[k] + RND_BIAS) >>> SHIFT);
            im_rnd[k]   = rnd_t'((s3_im[k] + RND_BIAS) >>> SHIFT);
            nx_re[k]    = '0;
            nx_im[k]    = '0;
            lane_act[k] = k < int'(s3_ctl.radix);
            lane_ovf[k] = lane_act[k] && !s3_ctl.bypass &&
                          (clamps(re_rnd[k]) || clamps(im_rnd[k]));
            if (lane_act[k]) begin
                nx_bidx[k*wBankIdx +: wBankIdx]    = s3_ctl.bidx[k*wBankIdx +: wBankIdx];
                nx_baddr[k*wBankAddr +: wBankAddr] = s3_ctl.baddr[k*wBankAddr +: wBankAddr];
                if (s3_ctl.bypass) begin
                    nx_re[k] = s3_dr[k];
                    nx_im[k] = s3_di[k];
                end else begin
                    nx_re[k] = saturate(re_rnd[k]);
                    nx_im[k] = saturate(im_rnd[k]);
                end
            end
        end
        ovf_set = ce && s3_ctl.val && (|lane_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val        <= 1'b0;
            out_bank_index <= '0;
            out_bank_addr  <= '0;
            dout_real      <= '0;
            dout_imag      <= '0;
        end else if (ce) begin
            out_val        <= s3_ctl.val;
            out_bank_index <= nx_bidx;
            out_bank_addr  <= nx_baddr;
            for (int k = 0; k < NLANE; k++) begin
                dout_real[k*wData +: wData] <= nx_re[k];
                dout_imag[k*wData +: wData] <= nx_im[k];
            end
        end
    end

    // Sticky flag runs outside the ce gate so a clear is honoured during a stall; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_sticky <= 1'b0;
        else if (ovf_set) ovf_sticky <= 1'b1;
        else if (clr_ovf) ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_mrd_twdl_cmul_pipe.sv
// Directed bench for mrd_twdl_cmul_pipe: identity, rotation, rounding, saturation/sticky,
// stall ordering, bypass with lane masking, and mid-stream reset.
module tb_mrd_twdl_cmul_pipe;

    localparam int wData     = 30;
    localparam int wTw       = 16;
    localparam int NLANE     = 5;
    localparam int wBankIdx  = 3;
    localparam int wBankAddr = 8;
    localparam longint MAXV  = 536870911;
    localparam longint MINV  = -536870912;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       ce;
    logic                       in_val;
    logic [2:0]                 in_radix;
    logic                       in_bypass;
    logic [NLANE*wBankIdx-1:0]  in_bank_index;
    logic [NLANE*wBankAddr-1:0] in_bank_addr;
    logic [NLANE*wData-1:0]     din_real;
    logic [NLANE*wData-1:0]     din_imag;
    logic [NLANE*wTw-1:0]       tw_real;
    logic [NLANE*wTw-1:0]       tw_imag;
    logic                       clr_ovf;
    logic                       out_val;
    logic [NLANE*wBankIdx-1:0]  out_bank_index;
    logic [NLANE*wBankAddr-1:0] out_bank_addr;
    logic [NLANE*wData-1:0]     dout_real;
    logic [NLANE*wData-1:0]     dout_imag;
    logic                       ovf_sticky;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    mrd_twdl_cmul_pipe #(
        .wData(wData), .wTw(wTw), .NLANE(NLANE), .wBankIdx(wBankIdx), .wBankAddr(wBankAddr)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_val(in_val), .in_radix(in_radix),
        .in_bypass(in_bypass), .in_bank_index(in_bank_index), .in_bank_addr(in_bank_addr),
        .din_real(din_real), .din_imag(din_imag), .tw_real(tw_real), .tw_imag(tw_imag),
        .clr_ovf(clr_ovf), .out_val(out_val), .out_bank_index(out_bank_index),
        .out_bank_addr(out_bank_addr), .dout_real(dout_real), .dout_imag(dout_imag),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input longint dr, input longint di,
                            input longint tr, input longint ti);
        din_real[k*wData +: wData] = dr[wData-1:0];
        din_imag[k*wData +: wData] = di[wData-1:0];
        tw_real[k*wTw +: wTw]      = tr[wTw-1:0];
        tw_imag[k*wTw +: wTw]      = ti[wTw-1:0];
    endtask

    task automatic set_side(input int k, input int idx, input int addr);
        in_bank_index[k*wBankIdx +: wBankIdx]  = idx[wBankIdx-1:0];
        in_bank_addr[k*wBankAddr +: wBankAddr] = addr[wBankAddr-1:0];
    endtask

    task automatic drive(input logic v, input logic [2:0] r, input logic b);
        in_val    = v;
        in_radix  = r;
        in_bypass = b;
    endtask

    function automatic logic signed [63:0] ore(input int k);
        logic signed [wData-1:0] t;
        t = dout_real[k*wData +: wData];
        return 64'(t);
    endfunction

    function automatic logic signed [63:0] oim(input int k);
        logic signed [wData-1:0] t;
        t = dout_imag[k*wData +: wData];
        return 64'(t);
    endfunction

    function automatic logic signed [63:0] obi(input int k);
        return 64'(out_bank_index[k*wBankIdx +: wBankIdx]);
    endfunction

    function automatic logic signed [63:0] oba(input int k);
        return 64'(out_bank_addr[k*wBankAddr +: wBankAddr]);
    endfunction

    int     g;
    int     n_got;
    longint got_addr [16];
    longint got_re   [16];
    int     got_cyc  [16];

    initial begin
        // Reset held while ce/in_val are active: nothing may leak through.
        rst_n = 1'b0; ce = 1'b1; clr_ovf = 1'b0;
        in_bank_index = '0; in_bank_addr = '0;
        for (int k = 0; k < NLANE; k++) begin
            set_lane(k, 321, 654, 16384, 0);
            set_side(k, 3, 77);
        end
        drive(1'b1, 3'd5, 1'b0);
        tick(); tick();
        chk("reset_out_val", out_val, 0);
        chk("reset_dout_re0", ore(0), 0);
        chk("reset_addr0", oba(0), 0);
        chk("reset_ovf", ovf_sticky, 0);
        drive(1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Identity on lane 0; other lanes carry data but radix=1 masks them.
        for (int k = 0; k < NLANE; k++) begin
            set_lane(k, 777, -777, 16384, 0);
            set_side(k, k + 1, 10 + k);
        end
        set_lane(0, 1000, 0, 16384, 0);
        drive(1'b1, 3'd1, 1'b0);
        tick();
        in_val = 1'b0;
        tick(); tick();
        chk("lat_not_early", out_val, 0);
        tick();
        chk("id_val", out_val, 1);
        chk("id_re0", ore(0), 1000);
        chk("id_im0", oim(0), 0);
        chk("id_re1_masked", ore(1), 0);
        chk("id_im4_masked", oim(4), 0);
        chk("id_idx0", obi(0), 1);
        chk("id_addr0", oba(0), 10);
        chk("id_addr1_masked", oba(1), 0);
        chk("id_ovf", ovf_sticky, 0);
        tick();
        chk("id_single_val", out_val, 0);

        // Rotation by j (radix 5) followed back to back by rounding (radix 3).
        for (int k = 0; k < NLANE; k++) begin
            set_lane(k, 1000, 500, 0, 16384);
            set_side(k, (k + 3) % 8, 100 + k);
        end
        drive(1'b1, 3'd5, 1'b0);
        tick();
        set_lane(0, 3, 0, 8192, 0);
        set_lane(1, -3, 0, 8192, 0);
        set_lane(2, 1, 0, 8192, 0);
        set_lane(3, 5, 5, 8192, 0);
        set_lane(4, 5, 5, 8192, 0);
        for (int k = 0; k < NLANE; k++) set_side(k, k, 200 + k);
        drive(1'b1, 3'd3, 1'b0);
        tick();
        in_val = 1'b0;
        tick(); tick();
        chk("rot_val", out_val, 1);
        chk("rot_re0", ore(0), -500);
        chk("rot_im0", oim(0), 1000);
        chk("rot_re4", ore(4), -500);
        chk("rot_im4", oim(4), 1000);
        chk("rot_idx2", obi(2), 5);
        chk("rot_addr4", oba(4), 104);
        tick();
        chk("rnd_val", out_val, 1);
        chk("rnd_pos3", ore(0), 2);
        chk("rnd_neg3", ore(1), -1);
        chk("rnd_half", ore(2), 1);
        chk("rnd_im0", oim(0), 0);
        chk("rnd_re3_masked", ore(3), 0);
        chk("rnd_addr3_masked", oba(3), 0);
        chk("rnd_addr2", oba(2), 202);
        chk("rnd_ovf", ovf_sticky, 0);

        // Saturation, then set-beats-clear, then a lone clear.
        for (int k = 0; k < NLANE; k++) set_lane(k, MAXV, MAXV, 16384, 16384);
        drive(1'b1, 3'd1, 1'b0);
        tick();
        in_val = 1'b0;
        tick(); tick(); tick();
        chk("sat_re0", ore(0), 0);
        chk("sat_im0", oim(0), MAXV);
        chk("sat_lane1_masked", oim(1), 0);
        chk("sat_ovf", ovf_sticky, 1);
        in_val = 1'b1;
        tick();
        in_val = 1'b0;
        tick(); tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("sat2_val", out_val, 1);
        chk("set_wins_clear", ovf_sticky, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clear_alone", ovf_sticky, 0);
        repeat (5) tick();
        chk("invalid_no_ovf", ovf_sticky, 0);

        // Stall: 8 tagged groups, ce low for 3 cycles; junk offered during the stall.
        for (int k = 0; k < NLANE; k++) begin
            set_lane(k, 0, 0, 16384, 0);
            set_side(k, 0, 0);
        end
        g = 0;
        n_got = 0;
        for (int c = 0; c < 20; c++) begin
            ce = !(c >= 4 && c <= 6);
            if (!ce) begin
                set_lane(0, 99, 0, 16384, 0);
                set_side(0, 0, 99);
                drive(1'b1, 3'd5, 1'b0);
            end else if (g < 8) begin
                set_lane(0, g, 0, 16384, 0);
                set_side(0, 0, g);
                drive(1'b1, 3'd5, 1'b0);
                g++;
            end else begin
                in_val = 1'b0;
            end
            if (out_val && ce) begin
                if (n_got < 16) begin
                    got_addr[n_got] = oba(0);
                    got_re[n_got]   = ore(0);
                    got_cyc[n_got]  = c;
                end
                n_got++;
            end
            tick();
        end
        chk("stall_count", n_got, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stall_addr%0d", i), got_addr[i], i);
            chk($sformatf("stall_cyc%0d", i), got_cyc[i], i + 7);
        end
        chk("stall_re7", got_re[7], 7);

        // Bypass with radix 3 and garbage twiddles, three groups back to back.
        set_lane(0, MAXV, -5, 16384, 16384);
        set_lane(1, MINV, 123, -1, 77);
        set_lane(2, 12345, -6789, 999, -999);
        set_lane(3, 42, 42, 1, 1);
        set_lane(4, 43, 43, 1, 1);
        for (int k = 0; k < NLANE; k++) set_side(k, k + 1, 50 + k);
        drive(1'b1, 3'd3, 1'b1);
        tick(); tick(); tick();
        in_val = 1'b0;
        tick();
        chk("byp_val", out_val, 1);
        chk("byp_re0", ore(0), MAXV);
        chk("byp_im0", oim(0), -5);
        chk("byp_re1", ore(1), MINV);
        chk("byp_im2", oim(2), -6789);
        chk("byp_re3_masked", ore(3), 0);
        chk("byp_im4_masked", oim(4), 0);
        chk("byp_idx3_masked", obi(3), 0);
        chk("byp_addr2", oba(2), 52);
        chk("byp_ovf", ovf_sticky, 0);

        // Reset while two groups are still in flight.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_val", out_val, 0);
        chk("rst_re0", ore(0), 0);
        chk("rst_addr2", oba(2), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("no_stale_val%0d", i), out_val, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
